// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the OAM DMA bus arbiter.
// State encoding and default register/OAM addresses.
package dma_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } dmaState_t;

   localparam int          DMA_LENGTH_DEF   = 160;
   localparam logic [15:0] DMA_REG_ADDR_DEF = 16'hFF46;
   localparam logic [15:0] OAM_BASE_DEF     = 16'hFE00;

endpackage

// File: rtl/dma_bus_arbiter.sv
// OAM DMA bus arbiter between CPU and MMU.
// Passes CPU traffic through when idle, owns the bus during a transfer.
module dma_bus_arbiter
   import dma_bus_arbiter_pkg::*;
#(
   parameter int          DMA_LENGTH   = DMA_LENGTH_DEF,
   parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
   parameter logic [15:0] OAM_BASE     = OAM_BASE_DEF
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [15:0] iCpuAddr,
   input  logic [7:0]  iCpuData,
   input  logic        iCpuWe,
   output logic [7:0]  oCpuData,
   output logic        oCpuStall,
   output logic [15:0] oMmuAddr,
   output logic [7:0]  oMmuData,
   output logic        oMmuWe,
   input  logic [7:0]  iMmuData,
   output logic        oDmaBusy
);

   localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

   dmaState_t  state;
   logic [7:0] srcHi;
   logic [7:0] index;
   logic       trigger;
   logic       mmuWe;

   assign trigger = (state == IDLE) && iCpuWe
                 && (iCpuAddr == DMA_REG_ADDR);

   // Transfer sequencer: alternate READ/WRITE per byte, index counts bytes.
   always_ff @(posedge iClock) begin
      if (!iReset) begin
         state <= IDLE;
         srcHi <= 8'h00;
         index <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               if (trigger) begin
                  srcHi <= iCpuData;
                  index <= 8'h00;
                  state <= READ;
               end
            end
            READ: begin
               state <= WRITE;
            end
            WRITE: begin
               if (index == LAST_INDEX) begin
                  state <= IDLE;
               end else begin
                  index <= index + 8'd1;
                  state <= READ;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Bus steering: CPU pass-through when idle, DMA source/OAM otherwise.
   always_comb begin
      oMmuAddr = iCpuAddr;
      oMmuData = iCpuData;
      mmuWe    = iCpuWe;
      oCpuData = iMmuData;
      unique case (state)
         READ: begin
            oMmuAddr = {srcHi, index};
            oMmuData = 8'h00;
            mmuWe    = 1'b0;
            oCpuData = 8'h00;
         end
         WRITE: begin
            oMmuAddr = OAM_BASE + {8'h00, index};
            oMmuData = iMmuData;
            mmuWe    = 1'b1;
            oCpuData = 8'h00;
         end
         default: begin
         end
      endcase
   end

   // Reset forces the write strobe low even while the CPU drives a write.
   assign oMmuWe    = mmuWe & iReset;
   assign oDmaBusy  = (state != IDLE);
   assign oCpuStall = (state != IDLE);

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter DMA_LENGTH, default 160, bytes per OAM DMA transfer.
REQ-002 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, DMA trigger register address.
REQ-003 SHALL have parameter OAM_BASE, default 16'hFE00, destination base address.
REQ-004 SHALL have port iClock  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port iReset  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port iCpuAddr  input  16  CPU bus address.
REQ-007 SHALL have port iCpuData  input  8  CPU write data.
REQ-008 SHALL have port iCpuWe  input  1  CPU write enable.
REQ-009 SHALL have port oCpuData  output  8  read data returned to the CPU.
REQ-010 SHALL have port oCpuStall  output  1  CPU must hold its current micro-op.
REQ-011 SHALL have port oMmuAddr  output  16  address to the MMU.
REQ-012 SHALL have port oMmuData  output  8  write data to the MMU.
REQ-013 SHALL have port oMmuWe  output  1  MMU write enable.
REQ-014 SHALL have port iMmuData  input  8  MMU read data, valid one cycle after the address.
REQ-015 SHALL have port oDmaBusy  output  1  DMA transfer in progress.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE; the reset state is IDLE.
REQ-017 In IDLE the block SHALL pass through: oMmuAddr=iCpuAddr, oMmuData=iCpuData, oMmuWe=iCpuWe, oCpuData=iMmuData, oCpuStall=0.
REQ-018 In IDLE, a CPU write with iCpuAddr==DMA_REG_ADDR (cycle T) SHALL be forwarded to the MMU, SHALL latch iCpuData as source high byte, SHALL clear the 8-bit byte index, and SHALL enter READ at T+1.
REQ-019 READ SHALL drive oMmuAddr={srcHi,index}, oMmuWe=0; next state WRITE.
REQ-020 WRITE SHALL drive oMmuAddr=OAM_BASE+index, oMmuData=iMmuData, oMmuWe=1.
REQ-021 In WRITE, if index==DMA_LENGTH-1 the next state SHALL be IDLE; otherwise index SHALL increment and the next state SHALL be READ.
REQ-022 Timing SHALL be: byte n is read at T+1+2n and written at T+2+2n; the last write is at T+320; IDLE is re-entered at T+321.
REQ-023 oDmaBusy and oCpuStall SHALL be 1 exactly while the state is not IDLE (T+1..T+320), decoded from registered state.
REQ-024 While busy, CPU inputs SHALL be ignored; a DMA_REG_ADDR write during busy SHALL NOT retrigger or alter srcHi; oCpuData SHALL be 8'h00.
REQ-025 Any srcHi value 00–FF SHALL be accepted verbatim; source address wrap and validity are not checked.
REQ-026 A trigger write in the same cycle IDLE is re-entered (T+321) SHALL start a new transfer normally.
REQ-027 The index SHALL be 8 bits; DMA_LENGTH SHALL be in 1..256.

Reset
REQ-028 With iReset==0 at a clock edge: state=IDLE, index=0, srcHi=0, oDmaBusy=0, oCpuStall=0, oMmuWe=0 (a forced write-disable during reset).
REQ-029 Reset asserted mid-transfer SHALL abort immediately; no further MMU writes after that edge; OAM bytes already written are retained.

Structure
REQ-030 State encodings and DMA_REG_ADDR/OAM_BASE defaults SHALL live in the shared definitions include (aDefinitions.v).
REQ-031 The block SHALL be a single module with no sub-modules; the FSM and index counter SHALL be inline.
REQ-032 The block SHALL sit between DZCPU and MMU inside pGB; DZCPU SHALL honor oCpuStall by not advancing its micro-PC.

Verification
REQ-033 Pass-through: CPU write 8'hA5 @16'hC000 then read @16'hC000 -> oMmuWe=1 on the write cycle; oCpuData=8'hA5 next cycle; oCpuStall=0 throughout.
REQ-034 Full DMA: preload C000–C09F with index^8'h5A, write 8'hC0 @FF46 -> FE00–FE9F match; oDmaBusy high exactly 320 cycles; 160 MMU writes.
REQ-035 Retrigger ignored: write 8'hD0 @FF46 at T+50 -> source stays C0xx, completion still at T+320.
REQ-036 Reset mid-op: drive iReset=0 at T+101 (byte 50 read) -> FE00–FE31 written, FE32 untouched, oDmaBusy=0 after the edge.
REQ-037 Back-to-back: trigger at T+321 -> second transfer starts at T+322 with no lost cycle.
REQ-038 DMA_LENGTH=1 build: trigger -> exactly one read and one write; idle at T+3.
